// File: rtl/atuador_de_dampers.sv
// atuador_de_dampers: sequences six damper motors one at a time, with dead time, travel timeout and per-damper faults.
`timescale 1ns/1ps
module atuador_de_dampers #(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int DEAD_CICLOS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cmdDamper,
    input  logic [5:0] fimCursoAberto,
    input  logic [5:0] fimCursoFechado,
    input  logic       limparFalha,
    output logic [5:0] motorAbrir,
    output logic [5:0] motorFechar,
    output logic [5:0] estadoDamper,
    output logic [5:0] falhaDamper,
    output logic       alarmeFalha,
    output logic       ocupado
);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int DW = $clog2(DEAD_CICLOS + 1);
    typedef enum logic [1:0] {SCAN, PAUSA, MOVE} estado_t;
    estado_t    est_q, est_d;
    logic [5:0] ab_m_q, ab_q, fe_m_q, fe_q;
    logic [2:0] ptr_q, ptr_d, idx_q, idx_d, ptr_inc, idx_inc;
    logic       dir_q, dir_d, alvo, alarme_q;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [5:0] falha_q, falha_d, abrir_q, abrir_d, fechar_q, fechar_d;
    logic [5:0] pos_q, need, both, set_f;
    assign both    = ab_q & fe_q;
    assign need    = ~falha_q & ((cmdDamper & ~ab_q) | (~cmdDamper & ~fe_q));
    assign ptr_inc = (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
    assign idx_inc = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    assign alvo    = dir_q ? ab_q[idx_q] : fe_q[idx_q];
    always_comb begin
        est_d  = est_q;
        ptr_d  = ptr_q;
        idx_d  = idx_q;
        dir_d  = dir_q;
        tmr_d  = tmr_q;
        dead_d = dead_q;
        set_f  = (est_q != PAUSA) ? both : 6'b0;
        case (est_q)
            SCAN: begin
                if (need[ptr_q]) begin
                    est_d  = PAUSA;
                    idx_d  = ptr_q;
                    dir_d  = cmdDamper[ptr_q];
                    dead_d = '0;
                end else ptr_d = ptr_inc;
            end
            PAUSA: begin
                if (dead_q >= DW'(DEAD_CICLOS - 1)) begin
                    est_d = MOVE;
                    tmr_d = '0;
                end else dead_d = dead_q + DW'(1);
            end
            MOVE: begin
                if (alvo) begin
                    est_d = SCAN;
                    ptr_d = idx_inc;
                end else if (cmdDamper[idx_q] != dir_q) begin
                    est_d  = PAUSA;
                    dir_d  = cmdDamper[idx_q];
                    dead_d = '0;
                end else if (tmr_q >= TW'(TIMEOUT_CICLOS - 1)) begin
                    est_d        = SCAN;
                    ptr_d        = idx_inc;
                    set_f[idx_q] = 1'b1;
                end else tmr_d = tmr_q + TW'(1);
            end
            default: est_d = SCAN;
        endcase
        // a fault raised in the same cycle as the clear pulse survives it
        falha_d  = (limparFalha ? 6'b0 : falha_q) | set_f;
        abrir_d  = (est_d == MOVE && dir_d)  ? 6'(1) << idx_d : 6'b0;
        fechar_d = (est_d == MOVE && !dir_d) ? 6'(1) << idx_d : 6'b0;
    end
    always_ff @(posedge clk) begin
        ab_m_q <= fimCursoAberto;
        ab_q   <= ab_m_q;
        fe_m_q <= fimCursoFechado;
        fe_q   <= fe_m_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            est_q    <= SCAN;
            ptr_q    <= '0;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            tmr_q    <= '0;
            dead_q   <= '0;
            falha_q  <= '0;
            abrir_q  <= '0;
            fechar_q <= '0;
            pos_q    <= '0;
            alarme_q <= 1'b0;
        end else begin
            est_q    <= est_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            tmr_q    <= tmr_d;
            dead_q   <= dead_d;
            falha_q  <= falha_d;
            abrir_q  <= abrir_d;
            fechar_q <= fechar_d;
            pos_q    <= ab_q & ~fe_q;
            alarme_q <= |falha_d;
        end
    end
    assign motorAbrir   = abrir_q;
    assign motorFechar  = fechar_q;
    assign estadoDamper = pos_q;
    assign falhaDamper  = falha_q;
    assign alarmeFalha  = alarme_q;
    assign ocupado      = est_q != SCAN;
endmodule
